// File: rtl/spart_pkg.sv
// Shared types for the SPART transmitter: serialiser FSM states and parity selections.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } spart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/spart_fifo.sv
// Synchronous DATA_W x DEPTH FIFO with show-ahead head word; pointers carry an extra wrap bit
// so full and empty are told apart without a separate flag.
module spart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spart_tx_fifo.sv
// SPART transmitter: buffered words are serialised LSB-first as start, data, optional parity
// and stop bits, advancing one bit per baud_clk strobe, with back-to-back frames when queued.
module spart_tx_fifo
  import spart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_clk,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          txd,
  output logic                          tbr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf
);

  localparam int               BIT_W     = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("spart_tx_fifo: DATA_W must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("spart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("spart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  spart_tx_state_t   state, state_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic              acc, acc_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic              stop_cnt, stop_cnt_d;
  logic              txd_d;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  spart_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d    = state;
    txd_d      = txd;
    sh_d       = sh;
    acc_d      = acc;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    pop        = 1'b0;
    if (baud_clk) begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            acc_d   = 1'b0;
            txd_d   = 1'b0;
            state_d = START;
          end
        end
        START: begin
          txd_d     = sh[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          sh_d  = sh >> 1;
          acc_d = acc ^ sh[0];
          if (bit_cnt == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              txd_d   = (PARITY == PAR_ODD) ? ~(acc ^ sh[0]) : (acc ^ sh[0]);
              state_d = PAR;
            end else begin
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            txd_d     = sh[1];
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
        PAR: begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_cnt == LAST_STOP) begin
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (!fifo_empty) begin
              pop     = 1'b1;
              sh_d    = fifo_dout;
              acc_d   = 1'b0;
              txd_d   = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      sh       <= '0;
      acc      <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_d;
      txd      <= txd_d;
      sh       <= sh_d;
      acc      <= acc_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      ovf      <= wr_en & fifo_full;
    end
  end

  assign tbr  = ~fifo_full;
  assign busy = (state != IDLE) | (fifo_cnt != '0);

  // The baud generator must deliver single-cycle strobes.
  baud_single_cycle: assert property (@(posedge clk) disable iff (rst) baud_clk |=> !baud_clk);

endmodule
